// File: rtl/pipe_hazard_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and constants for the pipeline hazard controller
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, MULT = 2'd2} hz_state_t;
  localparam logic [4:0] XZR = 5'd31;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: ID/EX hazard inputs and pipeline control outputs
interface pipe_hazard_ctrl_if #(parameter int CNT_W = 16);
  logic [4:0] id_ra, id_rb, ex_rw;
  logic id_uses_ra, id_uses_rb, ex_regwrite, ex_memread, ex_is_mult, ex_br_taken;
  logic pc_write_en, pc_sel_br, ifid_write_en, ifid_flush, idex_hold, idex_bubble, exmem_bubble;
  logic [1:0] state_o;
  logic [CNT_W-1:0] stall_cycles, flush_events;
  modport master (
    output id_ra, id_rb, ex_rw, id_uses_ra, id_uses_rb, ex_regwrite, ex_memread, ex_is_mult, ex_br_taken,
    input pc_write_en, pc_sel_br, ifid_write_en, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
    input state_o, stall_cycles, flush_events
  );
  modport slave (
    input id_ra, id_rb, ex_rw, id_uses_ra, id_uses_rb, ex_regwrite, ex_memread, ex_is_mult, ex_br_taken,
    output pc_write_en, pc_sel_br, ifid_write_en, ifid_flush, idex_hold, idex_bubble, exmem_bubble,
    output state_o, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: counter that sticks at all-ones instead of wrapping
module sat_counter #(parameter int W = 16) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for load-use, taken branches and multi-cycle multiply
module pipe_hazard_ctrl import cpu_ctrl_pkg::*; #(
  parameter int MULT_LATENCY = 4,
  parameter int FLUSH_DEPTH  = 1,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  hz_state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic load_use;
  assign load_use = bus.ex_memread & bus.ex_regwrite & (bus.ex_rw != XZR) &
                    ((bus.id_uses_ra & (bus.id_ra == bus.ex_rw)) | (bus.id_uses_rb & (bus.id_rb == bus.ex_rw)));
  assign bus.state_o = state;
  always_ff @(posedge clk)
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    bus.pc_write_en   = 1'b1;
    bus.pc_sel_br     = 1'b0;
    bus.ifid_write_en = 1'b1;
    bus.ifid_flush    = 1'b0;
    bus.idex_hold     = 1'b0;
    bus.idex_bubble   = 1'b0;
    bus.exmem_bubble  = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    if (reset) begin
      bus.pc_write_en   = 1'b0;
      bus.ifid_write_en = 1'b0;
      bus.ifid_flush    = 1'b1;
      bus.idex_bubble   = 1'b1;
      bus.exmem_bubble  = 1'b1;
      state_n = RUN;
      cnt_n   = '0;
    end else begin
      case (state)
        RUN:
          if (bus.ex_br_taken) begin
            bus.pc_sel_br   = 1'b1;
            bus.ifid_flush  = 1'b1;
            bus.idex_bubble = 1'b1;
            if (FLUSH_DEPTH > 1) begin
              state_n = FLUSH;
              cnt_n   = 4'(FLUSH_DEPTH - 2);
            end
          end else if (bus.ex_is_mult && MULT_LATENCY > 1) begin
            bus.pc_write_en   = 1'b0;
            bus.ifid_write_en = 1'b0;
            bus.idex_hold     = 1'b1;
            bus.exmem_bubble  = 1'b1;
            state_n = MULT;
            cnt_n   = 4'(MULT_LATENCY - 2);
          end else if (load_use) begin
            bus.pc_write_en   = 1'b0;
            bus.ifid_write_en = 1'b0;
            bus.idex_bubble   = 1'b1;
          end
        FLUSH: begin
          bus.ifid_flush  = 1'b1;
          bus.idex_bubble = 1'b1;
          state_n = (cnt == 4'd0) ? RUN : FLUSH;
          cnt_n   = (cnt == 4'd0) ? cnt : cnt - 4'd1;
        end
        MULT:
          if (cnt != 4'd0) begin
            bus.pc_write_en   = 1'b0;
            bus.ifid_write_en = 1'b0;
            bus.idex_hold     = 1'b1;
            bus.exmem_bubble  = 1'b1;
            cnt_n = cnt - 4'd1;
          end else state_n = RUN;
        default: state_n = RUN;
      endcase
    end
  end
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(!reset && !bus.pc_write_en), .count(bus.stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(!reset && state == RUN && bus.ex_br_taken), .count(bus.flush_events)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors and hand-written sequences for the hazard controller
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl_if #(.CNT_W(4)) bus ();
  pipe_hazard_ctrl #(.MULT_LATENCY(4), .FLUSH_DEPTH(3), .CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));
  // control word: {pc_write_en, pc_sel_br, ifid_write_en, ifid_flush, idex_hold, idex_bubble, exmem_bubble}
  localparam logic [6:0] C_RST = 7'b0001011, C_RUN = 7'b1010000, C_LU = 7'b0000010,
                         C_BR = 7'b1111010, C_FL = 7'b1011010, C_FRZ = 7'b0000101;
  typedef struct {
    string name;
    logic [4:0] ra, rb, rw;
    logic ua, ub, rwr, mrd;
    logic [6:0] exp;
  } vec_t;
  vec_t vecs[8];
  function automatic logic [6:0] ctrl();
    return {bus.pc_write_en, bus.pc_sel_br, bus.ifid_write_en, bus.ifid_flush,
            bus.idex_hold, bus.idex_bubble, bus.exmem_bubble};
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic [4:0] ra, rb, rw, input logic ua, ub, rwr, mrd, mul, br);
    bus.id_ra = ra; bus.id_rb = rb; bus.ex_rw = rw;
    bus.id_uses_ra = ua; bus.id_uses_rb = ub;
    bus.ex_regwrite = rwr; bus.ex_memread = mrd; bus.ex_is_mult = mul; bus.ex_br_taken = br;
  endtask
  task automatic idle(); drive(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic lu(); drive(5'd3, 5'd2, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic mid(); #4; endtask
  task automatic do_reset();
    reset = 1'b1; idle(); tick(); reset = 1'b0;
  endtask
  initial begin
    vecs[0] = '{"no_match",   5'd1,  5'd2, 5'd5,  1'b1, 1'b1, 1'b1, 1'b1, C_RUN};
    vecs[1] = '{"lu_ra",      5'd3,  5'd2, 5'd3,  1'b1, 1'b1, 1'b1, 1'b1, C_LU};
    vecs[2] = '{"lu_rb",      5'd1,  5'd7, 5'd7,  1'b1, 1'b1, 1'b1, 1'b1, C_LU};
    vecs[3] = '{"xzr",        5'd31, 5'd2, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, C_RUN};
    vecs[4] = '{"ra_unused",  5'd3,  5'd2, 5'd3,  1'b0, 1'b1, 1'b1, 1'b1, C_RUN};
    vecs[5] = '{"rb_unused",  5'd1,  5'd7, 5'd7,  1'b1, 1'b0, 1'b1, 1'b1, C_RUN};
    vecs[6] = '{"not_load",   5'd3,  5'd2, 5'd3,  1'b1, 1'b1, 1'b1, 1'b0, C_RUN};
    vecs[7] = '{"no_regwr",   5'd3,  5'd2, 5'd3,  1'b1, 1'b1, 1'b0, 1'b1, C_RUN};
    // reset outputs and post-reset state
    idle(); mid();
    chk("reset_ctrl", 16'(ctrl()), 16'(C_RST));
    tick(); reset = 1'b0; mid();
    chk("reset_state", 16'(bus.state_o), 16'd0);
    chk("reset_stall", 16'(bus.stall_cycles), 16'd0);
    chk("reset_flush", 16'(bus.flush_events), 16'd0);
    tick();
    foreach (vecs[i]) begin
      drive(vecs[i].ra, vecs[i].rb, vecs[i].rw, vecs[i].ua, vecs[i].ub, vecs[i].rwr, vecs[i].mrd, 1'b0, 1'b0);
      mid();
      chk(vecs[i].name, 16'(ctrl()), 16'(vecs[i].exp));
      chk({vecs[i].name, "_state"}, 16'(bus.state_o), 16'd0);
      tick();
    end
    chk("table_stalls", 16'(bus.stall_cycles), 16'd2);
    // single-cycle load-use stall
    do_reset(); lu(); mid();
    chk("lu_ctrl", 16'(ctrl()), 16'(C_LU));
    chk("lu_stall0", 16'(bus.stall_cycles), 16'd0);
    tick(); idle(); mid();
    chk("lu_release", 16'(ctrl()), 16'(C_RUN));
    chk("lu_stall1", 16'(bus.stall_cycles), 16'd1);
    tick();
    // branch with FLUSH_DEPTH=3, load-use and mult ignored during FLUSH
    do_reset(); drive(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); mid();
    chk("br_ctrl", 16'(ctrl()), 16'(C_BR));
    chk("br_state0", 16'(bus.state_o), 16'd0);
    tick(); lu(); bus.ex_is_mult = 1'b1; mid();
    chk("fl1_ctrl", 16'(ctrl()), 16'(C_FL));
    chk("fl1_state", 16'(bus.state_o), 16'd1);
    chk("fl_events", 16'(bus.flush_events), 16'd1);
    tick(); mid();
    chk("fl2_ctrl", 16'(ctrl()), 16'(C_FL));
    chk("fl2_state", 16'(bus.state_o), 16'd1);
    tick(); idle(); mid();
    chk("fl_done_ctrl", 16'(ctrl()), 16'(C_RUN));
    chk("fl_done_state", 16'(bus.state_o), 16'd0);
    chk("fl_no_stall", 16'(bus.stall_cycles), 16'd0);
    tick();
    // multiply occupying EX for 4 cycles; inputs ignored while in MULT
    do_reset(); drive(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); mid();
    chk("mul1_ctrl", 16'(ctrl()), 16'(C_FRZ));
    chk("mul1_state", 16'(bus.state_o), 16'd0);
    tick(); mid();
    chk("mul2_ctrl", 16'(ctrl()), 16'(C_FRZ));
    chk("mul2_state", 16'(bus.state_o), 16'd2);
    tick(); bus.ex_br_taken = 1'b1; mid();
    chk("mul3_ctrl", 16'(ctrl()), 16'(C_FRZ));
    chk("mul3_state", 16'(bus.state_o), 16'd2);
    tick(); mid();
    chk("mul4_release", 16'(ctrl()), 16'(C_RUN));
    chk("mul4_state", 16'(bus.state_o), 16'd2);
    tick(); idle(); mid();
    chk("mul5_state", 16'(bus.state_o), 16'd0);
    chk("mul_stalls", 16'(bus.stall_cycles), 16'd3);
    chk("mul_no_flush", 16'(bus.flush_events), 16'd0);
    tick();
    // priority: branch wins over mult and load-use
    do_reset(); lu(); bus.ex_is_mult = 1'b1; bus.ex_br_taken = 1'b1; mid();
    chk("prio_ctrl", 16'(ctrl()), 16'(C_BR));
    tick(); idle(); mid();
    chk("prio_state", 16'(bus.state_o), 16'd1);
    tick(); tick(); mid();
    chk("prio_back", 16'(bus.state_o), 16'd0);
    chk("prio_stall", 16'(bus.stall_cycles), 16'd0);
    chk("prio_flush", 16'(bus.flush_events), 16'd1);
    tick();
    // reset aborts MULT
    do_reset(); drive(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(); idle(); reset = 1'b1; mid();
    chk("mrst_ctrl", 16'(ctrl()), 16'(C_RST));
    tick(); reset = 1'b0; mid();
    chk("mrst_state", 16'(bus.state_o), 16'd0);
    chk("mrst_stall", 16'(bus.stall_cycles), 16'd0);
    chk("mrst_ctrl2", 16'(ctrl()), 16'(C_RUN));
    tick();
    // saturation at 4-bit all-ones
    do_reset(); lu();
    for (int i = 0; i < 20; i++) tick();
    idle(); mid();
    chk("sat_stall", 16'(bus.stall_cycles), 16'd15);
    tick();
    for (int i = 0; i < 17; i++) begin
      bus.ex_br_taken = 1'b1; tick(); bus.ex_br_taken = 1'b0; tick(); tick();
    end
    mid();
    chk("sat_flush", 16'(bus.flush_events), 16'd15);
    chk("sat_stall_hold", 16'(bus.stall_cycles), 16'd15);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
